muldiv_unit: RTL and testbench

Iterative RV32M execute unit. It sits in the execute stage beside the ALU and is the consumer of the decoded funct3 operation for OP instructions with funct7 = 0000001. It accepts one operation through a valid/ready handshake and computes it over multiple cycles (shift-add multiply, restoring divide). It returns a single-cycle done pulse with a held result, so the pipeline stalls while the unit is busy.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_abs_neg.sv | 13 +
 rtl/muldiv_unit.sv | 141 ++++++++++++++
 tb/tb_muldiv_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;
  localparam int ITER = 32;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

endpackage

// File: rtl/muldiv_abs_neg.sv
// Conditional two's-complement negate: takes operand magnitudes on entry
// and restores the result sign in the FIX cycle.
module muldiv_abs_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide
// sharing one 64-bit accumulator, with a valid/ready request side and a done pulse.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic            kill_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [1:0]      state_o
);
  import muldiv_pkg::*;

  // Handshake: a request is taken on a rising edge where valid_i & ready_o & !kill_i;
  // the requester holds valid_i and operands until then. done_o pulses once per result.
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_FIX  = FIX;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] b_q;
  logic [63:0] acc_q, acc_step;
  logic [31:0] result_q;

  logic        accept, a_signed, b_signed, sa, sb, b_zero, overflow, special, neg_in;
  logic [31:0] a_mag, b_mag, special_res, div_word, fix_res;
  logic [32:0] rem_sh, diff, mul_sum;
  logic [63:0] fix_in, fix_out;

  assign ready_o  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign state_o  = state_q;
  assign accept   = valid_i & ready_o & ~kill_i;

  assign a_signed = (md_op_i == MD_MULH) || (md_op_i == MD_MULHSU) ||
                    (md_op_i == MD_DIV)  || (md_op_i == MD_REM);
  assign b_signed = (md_op_i == MD_MULH) || (md_op_i == MD_DIV) || (md_op_i == MD_REM);
  assign sa       = a_signed & src_a_i[31];
  assign sb       = b_signed & src_b_i[31];
  assign b_zero   = (src_b_i == 32'd0);
  assign overflow = ((md_op_i == MD_DIV) || (md_op_i == MD_REM)) &&
                    (src_a_i == INT_MIN) && (src_b_i == 32'hFFFF_FFFF);
  assign special  = md_op_i[2] & (b_zero | overflow);

  always_comb begin
    neg_in = 1'b0;
    case (md_op_i)
      MD_MULH:   neg_in = sa ^ sb;
      MD_MULHSU: neg_in = sa;
      MD_DIV:    neg_in = (sa ^ sb) & ~b_zero;
      MD_REM:    neg_in = sa;
      default:   neg_in = 1'b0;
    endcase
  end

  // md_op_i[1] distinguishes REM/REMU from DIV/DIVU.
  always_comb begin
    special_res = 32'd0;
    if (b_zero)
      special_res = md_op_i[1] ? src_a_i : DIV0_QUOT;
    else
      special_res = md_op_i[1] ? 32'd0 : INT_MIN;
  end

  muldiv_abs_neg #(.W(32)) u_abs_a (.val_i(src_a_i), .neg_i(sa), .val_o(a_mag));
  muldiv_abs_neg #(.W(32)) u_abs_b (.val_i(src_b_i), .neg_i(sb), .val_o(b_mag));

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    rem_sh   = acc_q[63:31];
    diff     = rem_sh - {1'b0, b_q};
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    acc_step = {mul_sum, acc_q[31:1]};
    if (op_q[2])
      acc_step = diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                          : {diff[31:0],   acc_q[30:0], 1'b1};
  end

  // The high word of a signed product needs the full 64-bit negate, not just 32.
  assign div_word = op_q[1] ? acc_q[63:32] : acc_q[31:0];
  assign fix_in   = op_q[2] ? {32'd0, div_word} : acc_q;

  muldiv_abs_neg #(.W(64)) u_fix (.val_i(fix_in), .neg_i(neg_q), .val_o(fix_out));

  assign fix_res = (!op_q[2] && (op_q != MD_MUL)) ? fix_out[63:32] : fix_out[31:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = special ? ST_DONE : ST_BUSY;
        else        state_d = ST_IDLE;
      end
      ST_BUSY: begin
        if (kill_i)                      state_d = ST_IDLE;
        else if (cnt_q == 5'(ITER - 1))  state_d = ST_FIX;
      end
      ST_FIX:  state_d = kill_i ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 3'd0;
      neg_q    <= 1'b0;
      b_q      <= 32'd0;
      acc_q    <= 64'd0;
      result_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= md_op_i;
        neg_q <= neg_in;
        b_q   <= b_mag;
        acc_q <= {32'd0, a_mag};
        cnt_q <= 5'd0;
        if (special) result_q <= special_res;
      end else if (state_q == ST_BUSY && !kill_i) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + 5'd1;
      end else if (state_q == ST_FIX && !kill_i) begin
        result_q <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: arithmetic results, latency, special cases,
// kill, back-to-back accept and asynchronous reset.
module tb_muldiv_unit;

  logic        clk, rst_n, valid, kill;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        ready, done;
  logic [31:0] result;
  logic [1:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
    .md_op_i(md_op), .src_a_i(src_a), .src_b_i(src_b), .kill_i(kill),
    .done_o(done), .result_o(result), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: issue one op from IDLE, return cycles-to-done (100 = timed out)
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic rdy_low);
    @(negedge clk);
    valid = 1'b1; md_op = op; src_a = a; src_b = b;
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 0; rdy_low = 1'b1; res = 32'hxxxx_xxxx;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (done) begin
        res = result;
        break;
      end
      if (ready) rdy_low = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; kill = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b exp 0", done); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h exp 0", result); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat; logic [31:0] res; logic rl;
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_7x-3: got %h exp ffffffeb", res); end
    n_tests++; if (lat != 34) begin n_fail++; $display("FAIL mul_latency: got %0d exp 34", lat); end
    n_tests++; if (rl !== 1'b1) begin n_fail++; $display("FAIL mul_ready_low: got %b exp 1", rl); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b exp 0", done); end
    n_tests++; if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result_held: got %h exp ffffffeb", result); end
  endtask

  task automatic test_mulh();
    int lat; logic [31:0] res; logic rl;
    run_op(OP_MULH, 32'h8000_0000, 32'h8000_0000, lat, res, rl);
    n_tests++; if (res !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_min_min: got %h exp 40000000", res); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mulhu_max: got %h exp fffffffe", res); end
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_m1_max: got %h exp ffffffff", res); end
    run_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, lat, res, rl);
    n_tests++; if (res !== 32'h0000_0001) begin n_fail++; $display("FAIL mulhu_2p32: got %h exp 00000001", res); end
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, res, rl);
    n_tests++; if (res !== 32'h0000_0000) begin n_fail++; $display("FAIL mul_2p32_low: got %h exp 0", res); end
  endtask

  task automatic test_div();
    int lat; logic [31:0] res; logic rl;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2: got %h exp fffffffd", res); end
    n_tests++; if (lat != 34) begin n_fail++; $display("FAIL div_latency: got %0d exp 34", lat); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_-7/2: got %h exp ffffffff", res); end
    run_op(OP_DIVU, 32'd100, 32'd7, lat, res, rl);
    n_tests++; if (res !== 32'd14) begin n_fail++; $display("FAIL divu_100/7: got %h exp 0000000e", res); end
    run_op(OP_REMU, 32'd100, 32'd7, lat, res, rl);
    n_tests++; if (res !== 32'd2) begin n_fail++; $display("FAIL remu_100/7: got %h exp 00000002", res); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7/-2: got %h exp fffffffd", res); end
    run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, lat, res, rl);
    n_tests++; if (res !== 32'd1) begin n_fail++; $display("FAIL rem_7/-2: got %h exp 00000001", res); end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max/1: got %h exp ffffffff", res); end
  endtask

  task automatic test_special();
    int lat; logic [31:0] res; logic rl;
    run_op(OP_DIV, 32'd5, 32'd0, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by0: got %h exp ffffffff", res); end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL div_by0_latency: got %0d exp 1", lat); end
    run_op(OP_REM, 32'd5, 32'd0, lat, res, rl);
    n_tests++; if (res !== 32'd5) begin n_fail++; $display("FAIL rem_by0: got %h exp 00000005", res); end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL rem_by0_latency: got %0d exp 1", lat); end
    run_op(OP_DIVU, 32'd5, 32'd0, lat, res, rl);
    n_tests++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0: got %h exp ffffffff", res); end
    run_op(OP_REMU, 32'd5, 32'd0, lat, res, rl);
    n_tests++; if (res !== 32'd5) begin n_fail++; $display("FAIL remu_by0: got %h exp 00000005", res); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, rl);
    n_tests++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h exp 80000000", res); end
    n_tests++; if (lat != 1) begin n_fail++; $display("FAIL div_ovf_latency: got %0d exp 1", lat); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, rl);
    n_tests++; if (res !== 32'd0) begin n_fail++; $display("FAIL rem_ovf: got %h exp 0", res); end
    run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, rl);
    n_tests++; if (res !== 32'd0) begin n_fail++; $display("FAIL divu_no_ovf: got %h exp 0", res); end
    n_tests++; if (lat != 34) begin n_fail++; $display("FAIL divu_no_ovf_latency: got %0d exp 34", lat); end
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; logic rl; logic got_done;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, res, rl);
    @(negedge clk);
    valid = 1'b1; md_op = OP_MUL; src_a = 32'd7; src_b = 32'd3;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (11) @(negedge clk);
    n_tests++; if (state !== 2'd1) begin n_fail++; $display("FAIL kill_pre_busy: got %0d exp 1", state); end
    kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    @(negedge clk);
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL kill_to_idle: got %0d exp 0", state); end
    n_tests++; if (result !== 32'd14) begin n_fail++; $display("FAIL kill_result_held: got %h exp 0000000e", result); end
    got_done = done;
    repeat (40) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    n_tests++; if (got_done !== 1'b0) begin n_fail++; $display("FAIL kill_no_done: got %b exp 0", got_done); end
    run_op(OP_DIVU, 32'd9, 32'd3, lat, res, rl);
    n_tests++; if (res !== 32'd3) begin n_fail++; $display("FAIL kill_then_divu: got %h exp 00000003", res); end
    n_tests++; if (lat != 34) begin n_fail++; $display("FAIL kill_then_latency: got %0d exp 34", lat); end
    // kill alongside valid in IDLE must block the accept
    @(negedge clk);
    valid = 1'b1; kill = 1'b1; md_op = OP_DIVU; src_a = 32'd9; src_b = 32'd3;
    @(posedge clk);
    #1 valid = 1'b0; kill = 1'b0;
    @(negedge clk);
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL kill_blocks_accept: got %0d exp 0", state); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2; logic [31:0] res1, res2;
    @(negedge clk);
    valid = 1'b1; md_op = OP_MUL; src_a = 32'd6; src_b = 32'd7;
    @(posedge clk);
    #1 md_op = OP_DIVU; src_a = 32'd9; src_b = 32'd2;
    lat1 = 0; res1 = 32'hxxxx_xxxx;
    while (lat1 < 100) begin
      @(negedge clk);
      lat1++;
      if (done) begin res1 = result; break; end
    end
    @(posedge clk);
    #1 valid = 1'b0;
    lat2 = 0; res2 = 32'hxxxx_xxxx;
    while (lat2 < 100) begin
      @(negedge clk);
      lat2++;
      if (done) begin res2 = result; break; end
    end
    n_tests++; if (res1 !== 32'd42) begin n_fail++; $display("FAIL b2b_first: got %h exp 0000002a", res1); end
    n_tests++; if (lat1 != 34) begin n_fail++; $display("FAIL b2b_first_latency: got %0d exp 34", lat1); end
    n_tests++; if (res2 !== 32'd4) begin n_fail++; $display("FAIL b2b_second: got %h exp 00000004", res2); end
    n_tests++; if (lat2 != 34) begin n_fail++; $display("FAIL b2b_second_latency: got %0d exp 34", lat2); end
  endtask

  task automatic test_async_reset();
    logic got_done;
    @(negedge clk);
    valid = 1'b1; md_op = OP_MUL; src_a = 32'd5; src_b = 32'd5;
    @(posedge clk);
    #1 valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b exp 1", ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got %b exp 0", done); end
    n_tests++; if (result !== 32'd0) begin n_fail++; $display("FAIL arst_result: got %h exp 0", result); end
    n_tests++; if (state !== 2'd0) begin n_fail++; $display("FAIL arst_state: got %0d exp 0", state); end
    @(negedge clk);
    rst_n = 1'b1;
    got_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) got_done = 1'b1;
    end
    n_tests++; if (got_done !== 1'b0) begin n_fail++; $display("FAIL arst_no_done: got %b exp 0", got_done); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
